// File: rtl/activity_monitor.sv
// Multi-channel activity monitor: per-line synchroniser, selectable edge detector,
// event counter, LED pulse-stretcher and windowed event-rate measurement.
module activity_monitor #(
  parameter int NUM_CH        = 4,
  parameter int COUNT_BITS    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 0,
  parameter int SATURATE      = 0,
  parameter int WINDOW_CYCLES = 1000000,
  parameter int RATE_BITS     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               sig,
  input  logic [2*NUM_CH-1:0]             edge_mode,
  input  logic                            clr,
  output logic [NUM_CH-1:0]               edge_o,
  output logic [NUM_CH*COUNT_BITS-1:0]    ctr_o,
  output logic [NUM_CH-1:0]               act_o,
  output logic [NUM_CH*RATE_BITS-1:0]     rate_o,
  output logic                            rate_valid
);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam int TIMER_W = $clog2(WINDOW_CYCLES);
  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [PRIME_W-1:0] PRIME_MAX  = PRIME_W'(SYNC_STAGES + 1);

  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] p_q, p_d;
  logic [NUM_CH-1:0] det;
  logic [NUM_CH-1:0] edge_q, edge_d;
  logic [NUM_CH-1:0] act_q, act_d;
  logic [PRIME_W-1:0] prime_q, prime_d;
  logic               primed;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               win_end;
  logic               rate_valid_q, rate_valid_d;

  logic [COUNT_BITS-1:0] ctr_q   [NUM_CH];
  logic [COUNT_BITS-1:0] ctr_d   [NUM_CH];
  logic [RATE_BITS-1:0]  acc_q   [NUM_CH];
  logic [RATE_BITS-1:0]  acc_d   [NUM_CH];
  logic [RATE_BITS-1:0]  acc_sum [NUM_CH];
  logic [RATE_BITS-1:0]  rate_q  [NUM_CH];
  logic [RATE_BITS-1:0]  rate_d  [NUM_CH];

  // Synchroniser chain; stage 0 samples the raw line.
  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
      logic [NUM_CH-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = sig;
        for (int j = 1; j < SYNC_STAGES; j++) begin
          sync_d[j] = sync_q[j-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < SYNC_STAGES; j++) begin
            sync_q[j] <= '0;
          end
        end else begin
          sync_q <= sync_d;
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign s = sig;
    end
  endgenerate

  // After reset the sync and previous-level flops hold 0 regardless of the line,
  // so detection stays masked until p has caught up with the real level.
  assign primed = (prime_q == PRIME_MAX);

  always_comb begin
    prime_d = primed ? prime_q : prime_q + PRIME_W'(1);
    p_d     = s;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      det[i] = 1'b0;
      case (edge_mode[2*i +: 2])
        MODE_RISE: det[i] = s[i] & ~p_q[i];
        MODE_FALL: det[i] = ~s[i] & p_q[i];
        MODE_BOTH: det[i] = s[i] ^ p_q[i];
        MODE_OFF:  det[i] = 1'b0;
        default:   det[i] = 1'b0;
      endcase
      if (!primed) det[i] = 1'b0;
    end
  end

  assign edge_d  = det;
  assign win_end = (timer_q == TIMER_LAST);

  always_comb begin
    timer_d      = timer_q + TIMER_W'(1);
    rate_valid_d = win_end & ~clr;
    if (clr || win_end) timer_d = '0;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ctr_d[i] = ctr_q[i];
      if (clr) begin
        ctr_d[i] = '0;
      end else if (det[i] && !((SATURATE != 0) && (ctr_q[i] == '1))) begin
        ctr_d[i] = ctr_q[i] + COUNT_BITS'(1);
      end

      // An edge on the terminal cycle is folded into the closing window.
      acc_sum[i] = (acc_q[i] == '1) ? acc_q[i] : acc_q[i] + RATE_BITS'(det[i]);
      acc_d[i]   = acc_sum[i];
      rate_d[i]  = rate_q[i];
      if (clr) begin
        acc_d[i]  = '0;
        rate_d[i] = '0;
      end else if (win_end) begin
        acc_d[i]  = '0;
        rate_d[i] = acc_sum[i];
      end
    end
  end

  generate
    if (HOLD_CYCLES > 0) begin : g_hold
      localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
      logic [HOLD_W-1:0] hold_q [NUM_CH];
      logic [HOLD_W-1:0] hold_d [NUM_CH];

      // act follows hold_d so the LED rises on the same edge as edge_o.
      always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
          hold_d[i] = hold_q[i];
          if (clr) begin
            hold_d[i] = '0;
          end else if (det[i]) begin
            hold_d[i] = HOLD_W'(HOLD_CYCLES);
          end else if (hold_q[i] != '0) begin
            hold_d[i] = hold_q[i] - HOLD_W'(1);
          end
          act_d[i] = (hold_d[i] != '0);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < NUM_CH; i++) begin
            hold_q[i] <= '0;
          end
        end else begin
          hold_q <= hold_d;
        end
      end
    end else begin : g_legacy
      always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
          act_d[i] = ctr_d[i][COUNT_BITS-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q          <= '0;
      prime_q      <= '0;
      edge_q       <= '0;
      act_q        <= '0;
      timer_q      <= '0;
      rate_valid_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ctr_q[i]  <= '0;
        acc_q[i]  <= '0;
        rate_q[i] <= '0;
      end
    end else begin
      p_q          <= p_d;
      prime_q      <= prime_d;
      edge_q       <= edge_d;
      act_q        <= act_d;
      timer_q      <= timer_d;
      rate_valid_q <= rate_valid_d;
      ctr_q        <= ctr_d;
      acc_q        <= acc_d;
      rate_q       <= rate_d;
    end
  end

  assign edge_o     = edge_q;
  assign act_o      = act_q;
  assign rate_valid = rate_valid_q;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign ctr_o[g*COUNT_BITS +: COUNT_BITS] = ctr_q[g];
      assign rate_o[g*RATE_BITS +: RATE_BITS]  = rate_q[g];
    end
  endgenerate

endmodule
